// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control unit and its RV32M engine.
// The mul/div types are only consumed when MULDIV_EN is defined.
package alu_ctrl_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_BGEU = 4'b0011;
   localparam logic [3:0] OP_SRL  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_BEQ  = 4'b1000;
   localparam logic [3:0] OP_BNE  = 4'b1001;
   localparam logic [3:0] OP_BLT  = 4'b1010;
   localparam logic [3:0] OP_BGE  = 4'b1011;
   localparam logic [3:0] OP_XOR  = 4'b1100;
   localparam logic [3:0] OP_SLTU = 4'b1101;
   localparam logic [3:0] OP_BLTU = 4'b1110;
   localparam logic [3:0] OP_SLT  = 4'b1111;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_ALU = 2'b10;
   localparam logic [1:0] ALUOP_JAL = 2'b11;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
   } md_op_e;

   typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M engine: shift-add multiply, restoring divide on magnitudes.
// Compiled only when MULDIV_EN is defined.
`ifdef MULDIV_EN
module muldiv_iter
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            flush,
   input  md_op_e          op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            idle,
   output logic            running,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int unsigned CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e       state;
   md_op_e          op_q;
   logic [CW-1:0]   count;
   logic [XLEN-1:0] hi, lo, mb;
   logic            sa_q, sb_q;

   logic            sa, sb, div_zero, div_ovf, is_div_q;
   logic [XLEN-1:0] ma, mb_in, special;
   logic [XLEN:0]   sum, shifted, diff;
   logic [XLEN-1:0] hi_nxt, lo_nxt, quo, rem, final_res;
   logic [2*XLEN-1:0] prod_raw, prod;

   assign idle    = (state == IDLE);
   assign running = (state == RUN);

   // Operand signs/magnitudes and the results that bypass iteration
   always_comb begin
      sa       = (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & src_a[XLEN-1];
      sb       = (op inside {MD_MULH, MD_DIV, MD_REM}) & src_b[XLEN-1];
      ma       = sa ? -src_a : src_a;
      mb_in    = sb ? -src_b : src_b;
      div_zero = (op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && (src_b == '0);
      div_ovf  = (op inside {MD_DIV, MD_REM}) && (src_a == MIN_NEG) && (src_b == '1);
      if (div_zero) special = (op inside {MD_DIV, MD_DIVU}) ? '1 : src_a;
      else          special = (op == MD_DIV) ? MIN_NEG : '0;
   end

   // One radix-2 step; {hi,lo} is product accumulator or remainder/quotient pair
   always_comb begin
      is_div_q = op_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
      sum      = {1'b0, hi} + (lo[0] ? {1'b0, mb} : {(XLEN+1){1'b0}});
      shifted  = {hi, lo[XLEN-1]};
      diff     = shifted - {1'b0, mb};
      if (is_div_q) begin
         if (shifted >= {1'b0, mb}) begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

   // Sign fix-up of the final step's outcome
   always_comb begin
      prod_raw = {hi_nxt, lo_nxt};
      prod     = (sa_q ^ sb_q) ? -prod_raw : prod_raw;
      quo      = (sa_q ^ sb_q) ? -lo_nxt : lo_nxt;
      rem      = sa_q ? -hi_nxt : hi_nxt;
      unique case (op_q)
         MD_MUL:                       final_res = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              final_res = quo;
         default:                      final_res = rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         count  <= '0;
         done   <= 1'b0;
         result <= '0;
         op_q   <= MD_MUL;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         mb     <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            count <= '0;
         end else begin
            unique case (state)
               IDLE: if (start) begin
                  op_q <= op;
                  sa_q <= sa;
                  sb_q <= sb;
                  mb   <= mb_in;
                  if (div_zero || div_ovf) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= special;
                  end else begin
                     state <= RUN;
                     count <= CW'(XLEN);
                     hi    <= '0;
                     lo    <= ma;
                  end
               end
               RUN: begin
                  hi    <= hi_nxt;
                  lo    <= lo_nxt;
                  count <= count - CW'(1);
                  if (count == CW'(1)) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= final_res;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`endif

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: ALUOp/Funct3/Funct7 decode plus, with MULDIV_EN defined,
// a multi-cycle RV32M engine that holds the pipeline via Stall/MdValid.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            InValid,
   input  logic            RType,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic            Flush,
   output logic [3:0]      Operation,
   output logic            IllegalOp,
   output logic            Stall,
   output logic            MdValid,
   output logic [XLEN-1:0] MdResult
);
`ifdef MULDIV_EN
   logic is_mop;
`endif

   always_comb begin
      Operation = OP_ADD;
      IllegalOp = 1'b0;
`ifdef MULDIV_EN
      is_mop    = 1'b0;
`endif
      unique case (ALUOp)
         ALUOP_MEM: Operation = OP_ADD;
         ALUOP_JAL: Operation = OP_AND;
         ALUOP_BR: begin
            unique case (Funct3)
               3'b000:  Operation = OP_BEQ;
               3'b001:  Operation = OP_BNE;
               3'b100:  Operation = OP_BLT;
               3'b101:  Operation = OP_BGE;
               3'b110:  Operation = OP_BLTU;
               3'b111:  Operation = OP_BGEU;
               default: begin
                  Operation = OP_AND;
                  IllegalOp = 1'b1;
               end
            endcase
         end
         default: begin
            if (RType && Funct7 == F7_MULDIV) begin
`ifdef MULDIV_EN
               is_mop    = 1'b1;
               Operation = OP_ADD;
`else
               Operation = OP_AND;
               IllegalOp = 1'b1;
`endif
            end else begin
               unique case (Funct3)
                  3'b000:  Operation = (RType && Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                  3'b001:  Operation = OP_SLL;
                  3'b010:  Operation = OP_SLT;
                  3'b011:  Operation = OP_SLTU;
                  3'b100:  Operation = OP_XOR;
                  3'b101:  Operation = (Funct7 == F7_ALT) ? OP_SRA : OP_SRL;
                  3'b110:  Operation = OP_OR;
                  default: Operation = OP_AND;
               endcase
               // I-type Funct7 bits are immediate, so only R-type is policed
               if (RType && Funct7 != F7_BASE && Funct7 != F7_ALT)
                  IllegalOp = 1'b1;
               if (RType && Funct7 == F7_ALT && Funct3 != 3'b000 && Funct3 != 3'b101)
                  IllegalOp = 1'b1;
            end
         end
      endcase
   end

`ifdef MULDIV_EN
   logic issue, md_idle, md_run;

   // Engine only accepts from IDLE; in DONE the EX instruction is the completing one
   assign issue = InValid & is_mop & ~Flush & md_idle;
   assign Stall = (issue | md_run) & ~Flush;

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk     (clk),
      .reset   (reset),
      .start   (issue),
      .flush   (Flush),
      .op      (md_op_e'(Funct3)),
      .src_a   (SrcA),
      .src_b   (SrcB),
      .idle    (md_idle),
      .running (md_run),
      .done    (MdValid),
      .result  (MdResult)
   );
`else
   logic unused_md;

   assign Stall     = 1'b0;
   assign MdValid   = 1'b0;
   assign MdResult  = '0;
   assign unused_md = ^{clk, reset, InValid, Flush, SrcA, SrcB};
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, mul/div scoreboard with completion timing.
module tb_alu_ctrl_seq;
   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            InValid = 1'b0;
   logic            RType = 1'b0;
   logic [1:0]      ALUOp = 2'b00;
   logic [6:0]      Funct7 = 7'b0;
   logic [2:0]      Funct3 = 3'b0;
   logic [XLEN-1:0] SrcA = '0;
   logic [XLEN-1:0] SrcB = '0;
   logic            Flush = 1'b0;
   logic [3:0]      Operation;
   logic            IllegalOp;
   logic            Stall;
   logic            MdValid;
   logic [XLEN-1:0] MdResult;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      string           name;
      logic [XLEN-1:0] val;
      int              cyc;
   } exp_t;
   exp_t sbq[$];

   alu_ctrl_seq #(.XLEN(XLEN)) dut (
      .clk(clk), .reset(reset), .InValid(InValid), .RType(RType), .ALUOp(ALUOp),
      .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
      .Operation(Operation), .IllegalOp(IllegalOp), .Stall(Stall),
      .MdValid(MdValid), .MdResult(MdResult)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every MdValid strobe must match the oldest expected completion
   always @(negedge clk) begin
      if (MdValid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mdvalid actual=%h cycle=%0d expected=no strobe", MdResult, cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, "_result"}, 64'(MdResult), 64'(e.val));
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic dec(input string name, input logic rt, input logic [1:0] op,
                      input logic [6:0] f7, input logic [2:0] f3,
                      input logic [3:0] eop, input logic eill);
      @(posedge clk); #1;
      InValid = 1'b0; RType = rt; ALUOp = op; Funct7 = f7; Funct3 = f3;
      @(negedge clk);
      check({name, "_op"}, 64'(Operation), 64'(eop));
      check({name, "_ill"}, 64'(IllegalOp), 64'(eill));
   endtask

   task automatic drive_mop(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      InValid = 1'b1; RType = 1'b1; ALUOp = 2'b10; Funct7 = 7'b0000001;
      Funct3 = f3; SrcA = a; SrcB = b;
   endtask

   // Issue one M-op, hold EX while stalled, then release the pipeline
   task automatic run_md(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit special);
      int t;
      int stalls;
      @(posedge clk); #1;
      drive_mop(f3, a, b);
      t = cyc;
      sbq.push_back('{name, exp, t + (special ? 1 : int'(XLEN) + 1)});
      stalls = 0;
      for (int i = 0; i < int'(XLEN) + 5; i++) begin
         @(negedge clk);
         if (!Stall) break;
         stalls++;
         @(posedge clk); #1;
      end
      check({name, "_stall_len"}, 64'(stalls), special ? 64'd1 : 64'(XLEN + 1));
      @(posedge clk); #1;
      InValid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_stall", 64'(Stall), 64'd0);
      check("rst_mdvalid", 64'(MdValid), 64'd0);
      check("rst_mdresult", 64'(MdResult), 64'd0);

      dec("sub_r",   1'b1, 2'b10, 7'b0100000, 3'b000, 4'b0101, 1'b0);
      dec("add_i",   1'b0, 2'b10, 7'b0100000, 3'b000, 4'b0010, 1'b0);
      dec("bltu",    1'b0, 2'b01, 7'b0000000, 3'b110, 4'b1110, 1'b0);
      dec("bgeu",    1'b0, 2'b01, 7'b0000000, 3'b111, 4'b0011, 1'b0);
      dec("br_ill",  1'b0, 2'b01, 7'b0000000, 3'b010, 4'b0000, 1'b1);
      dec("sltu",    1'b1, 2'b10, 7'b0000000, 3'b011, 4'b1101, 1'b0);
      dec("lw",      1'b0, 2'b00, 7'b1111111, 3'b010, 4'b0010, 1'b0);
      dec("jal",     1'b0, 2'b11, 7'b0000000, 3'b000, 4'b0000, 1'b0);
      dec("sra",     1'b1, 2'b10, 7'b0100000, 3'b101, 4'b0110, 1'b0);
      dec("srl",     1'b1, 2'b10, 7'b0000000, 3'b101, 4'b0100, 1'b0);
      dec("f7_bad",  1'b1, 2'b10, 7'b0000010, 3'b000, 4'b0010, 1'b1);
      dec("alt_xor", 1'b1, 2'b10, 7'b0100000, 3'b100, 4'b1100, 1'b1);
`ifdef MULDIV_EN
      dec("mop",     1'b1, 2'b10, 7'b0000001, 3'b000, 4'b0010, 1'b0);

      run_md("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      run_md("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
      run_md("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
      run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
      run_md("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
      run_md("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
      run_md("divu",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
      run_md("remu",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0);
      run_md("rem_ovf",3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
      run_md("div_ovf",3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      run_md("remu_z", 3'b111, 32'd5,        32'd0,        32'd5,        1'b1);
      run_md("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);

      // Abort via Flush ten cycles into a multiply
      @(posedge clk); #1;
      drive_mop(3'b000, 32'd7, 32'd3);
      t = cyc;
      repeat (10) begin @(posedge clk); #1; end
      Flush = 1'b1;
      @(negedge clk);
      check("flush_stall", 64'(Stall), 64'd0);
      check("flush_at", 64'(cyc - t), 64'd10);
      @(posedge clk); #1;
      Flush = 1'b0; InValid = 1'b0;
      @(negedge clk);
      check("flush_idle", 64'(Stall), 64'd0);
      repeat (XLEN + 4) @(negedge clk);
      check("flush_hold", 64'(MdResult), 64'hFFFFFFFF);

      // Flush and issue together: nothing starts
      @(posedge clk); #1;
      drive_mop(3'b000, 32'd7, 32'd3);
      Flush = 1'b1;
      @(negedge clk);
      check("flush_issue_stall", 64'(Stall), 64'd0);
      @(posedge clk); #1;
      Flush = 1'b0; InValid = 1'b0;
      @(negedge clk);
      check("flush_issue_idle", 64'(Stall), 64'd0);

      // Reset five cycles into a multiply
      @(posedge clk); #1;
      drive_mop(3'b000, 32'd7, 32'd3);
      repeat (5) begin @(posedge clk); #1; end
      reset = 1'b1; InValid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_run_mdresult", 64'(MdResult), 64'd0);
      check("rst_run_stall", 64'(Stall), 64'd0);
      repeat (XLEN + 4) @(negedge clk);
      run_md("mul_after_rst", 3'b000, 32'd7, 32'd3, 32'd21, 1'b0);
`else
      dec("mop_off", 1'b1, 2'b10, 7'b0000001, 3'b000, 4'b0000, 1'b1);
      @(posedge clk); #1;
      drive_mop(3'b100, 32'd100, 32'd7);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("off_stall", 64'(Stall), 64'd0);
      end
      repeat (XLEN + 4) @(negedge clk);
      check("off_mdresult", 64'(MdResult), 64'd0);
      @(posedge clk); #1;
      InValid = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sbq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
